// File: rtl/fft_peak_tracker.sv
// Per-frame peak magnitude and bin tracker for the 730 nm and 850 nm FFT bin windows.
// Optional feature macro PEAK_MAG_SQUARED_EN: squared magnitude metric, one extra pipeline stage.

module fft_peak_tracker #(
  parameter int ADC_DATLEN    = 12,
  parameter int FFT_VLEN      = 16,
  parameter int FFT_VLEN_LOG2 = 4,
  parameter int LO730         = 1,
  parameter int HI730         = 3,
  parameter int LO850         = 5,
  parameter int HI850         = 7
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2*ADC_DATLEN-1:0]  fft_x,
  input  logic                     fft_nd,
  input  logic                     fft_ovf,
  output logic [ADC_DATLEN-1:0]    max730,
  output logic [ADC_DATLEN-1:0]    max850,
  output logic [FFT_VLEN_LOG2-1:0] bin730,
  output logic [FFT_VLEN_LOG2-1:0] bin850,
  output logic                     valid,
  output logic                     frame_err
);

  localparam int W      = ADC_DATLEN;
  localparam int BW     = FFT_VLEN_LOG2;
  localparam int LAST_I = FFT_VLEN - 1;
  localparam logic [BW-1:0] LAST_BIN = LAST_I[BW-1:0];
  localparam logic [W-1:0]  MAG_SAT  = {W{1'b1}};

  logic [BW-1:0]  bin_q, bin_d;
  logic           cap_v_q;
  logic [2*W-1:0] cap_x_q;
  logic [BW-1:0]  cap_bin_q;
  logic           cap_last_q;

  logic           mag_v_q;
  logic [W-1:0]   mag_q;
  logic [BW-1:0]  mag_bin_q;
  logic           mag_last_q;

  logic [W-1:0]   mag_d;
  logic           pre_v;
  logic [BW-1:0]  pre_bin;
  logic           pre_last;
  logic           pipe_busy;

  logic           publish;
  logic           in_progress;
  logic           err_pub;
  logic           err_acc_q, err_acc_d;
  logic           valid_q, frame_err_q;

  logic [W-1:0]   out_max [2];
  logic [BW-1:0]  out_bin [2];

  always_comb begin
    bin_d = bin_q;
    if (fft_nd) begin
      bin_d = (bin_q == LAST_BIN) ? '0 : bin_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_q   <= '0;
      cap_v_q <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      cap_v_q <= fft_nd;
    end
  end

  // fft_x packs {imag, real}: imaginary occupies the first (most significant) half.
  always_ff @(posedge clk) begin
    if (fft_nd) begin
      cap_x_q    <= fft_x;
      cap_bin_q  <= bin_q;
      cap_last_q <= (bin_q == LAST_BIN);
    end
  end

`ifdef PEAK_MAG_SQUARED_EN
  logic signed [2*W-1:0] re_w, im_w;
  logic                  prod_v_q;
  logic [2*W-1:0]        sq_re_q, sq_im_q, sq_sum, sq_shift;
  logic [BW-1:0]         prod_bin_q;
  logic                  prod_last_q;

  assign re_w = {{W{cap_x_q[W-1]}}, cap_x_q[W-1:0]};
  assign im_w = {{W{cap_x_q[2*W-1]}}, cap_x_q[2*W-1:W]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prod_v_q <= 1'b0;
    end else begin
      prod_v_q <= cap_v_q;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_v_q) begin
      sq_re_q     <= re_w * re_w;
      sq_im_q     <= im_w * im_w;
      prod_bin_q  <= cap_bin_q;
      prod_last_q <= cap_last_q;
    end
  end

  // Sum of squares never exceeds 2^(2W-1), so 2W bits hold it without wrap.
  assign sq_sum    = sq_re_q + sq_im_q;
  assign sq_shift  = sq_sum >> (W - 1);
  assign mag_d     = (|sq_shift[2*W-1:W]) ? MAG_SAT : sq_shift[W-1:0];
  assign pre_v     = prod_v_q;
  assign pre_bin   = prod_bin_q;
  assign pre_last  = prod_last_q;
  assign pipe_busy = cap_v_q | prod_v_q | mag_v_q;
`else
  logic [W:0] re_ext, im_ext, re_abs, im_abs, abs_sum;

  // One extra bit keeps |-2^(W-1)| exact before saturation.
  assign re_ext    = {cap_x_q[W-1], cap_x_q[W-1:0]};
  assign im_ext    = {cap_x_q[2*W-1], cap_x_q[2*W-1:W]};
  assign re_abs    = re_ext[W] ? -re_ext : re_ext;
  assign im_abs    = im_ext[W] ? -im_ext : im_ext;
  assign abs_sum   = re_abs + im_abs;
  assign mag_d     = abs_sum[W] ? MAG_SAT : abs_sum[W-1:0];
  assign pre_v     = cap_v_q;
  assign pre_bin   = cap_bin_q;
  assign pre_last  = cap_last_q;
  assign pipe_busy = cap_v_q | mag_v_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mag_v_q <= 1'b0;
    end else begin
      mag_v_q <= pre_v;
    end
  end

  always_ff @(posedge clk) begin
    if (pre_v) begin
      mag_q      <= mag_d;
      mag_bin_q  <= pre_bin;
      mag_last_q <= pre_last;
    end
  end

  // A frame is live from its first accepted bin until its last bin leaves the pipeline.
  assign publish     = mag_v_q & mag_last_q;
  assign in_progress = fft_nd | (bin_q != '0) | pipe_busy;
  assign err_pub     = err_acc_q | fft_ovf;

  always_comb begin
    err_acc_d = err_acc_q;
    if (publish) begin
      err_acc_d = 1'b0;
    end else if (fft_ovf && in_progress) begin
      err_acc_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_acc_q   <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      err_acc_q   <= err_acc_d;
      valid_q     <= publish;
      frame_err_q <= publish & err_pub;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_win
    localparam int LO_I = (gi == 0) ? LO730 : LO850;
    localparam int HI_I = (gi == 0) ? HI730 : HI850;
    localparam logic [BW-1:0] LO_B = LO_I[BW-1:0];
    localparam logic [BW-1:0] HI_B = HI_I[BW-1:0];

    logic          hit;
    logic [W-1:0]  run_max_q, run_max_d, out_max_q;
    logic [BW-1:0] run_bin_q, run_bin_d, out_bin_q;

    // Strict compare: on a tie the earlier (lower) bin is kept.
    always_comb begin
      hit       = mag_v_q && (mag_bin_q >= LO_B) && (mag_bin_q <= HI_B) && (mag_q > run_max_q);
      run_max_d = hit ? mag_q : run_max_q;
      run_bin_d = hit ? mag_bin_q : run_bin_q;
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        run_max_q <= '0;
        run_bin_q <= LO_B;
        out_max_q <= '0;
        out_bin_q <= '0;
      end else if (publish) begin
        run_max_q <= '0;
        run_bin_q <= LO_B;
        if (!err_pub) begin
          out_max_q <= run_max_d;
          out_bin_q <= run_bin_d;
        end
      end else begin
        run_max_q <= run_max_d;
        run_bin_q <= run_bin_d;
      end
    end

    assign out_max[gi] = out_max_q;
    assign out_bin[gi] = out_bin_q;
  end

  assign max730    = out_max[0];
  assign bin730    = out_bin[0];
  assign max850    = out_max[1];
  assign bin850    = out_bin[1];
  assign valid     = valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Bench for fft_peak_tracker: directed frame table, mid-frame reset, and random frames vs a frame-level model.
// Honours PEAK_MAG_SQUARED_EN to match the DUT build.

module tb_fft_peak_tracker;

  localparam int W     = 12;
  localparam int N     = 16;
  localparam int BW    = 4;
  localparam int LO730 = 1;
  localparam int HI730 = 3;
  localparam int LO850 = 5;
  localparam int HI850 = 7;
`ifdef PEAK_MAG_SQUARED_EN
  localparam int LAT = 3;
  localparam int NV  = 1;
`else
  localparam int LAT = 2;
  localparam int NV  = 7;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2*W-1:0] fft_x;
  logic          fft_nd;
  logic          fft_ovf;
  logic [W-1:0]  max730, max850;
  logic [BW-1:0] bin730, bin850;
  logic          valid, frame_err;

  always #5 clk = ~clk;

  fft_peak_tracker dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .fft_x     (fft_x),
    .fft_nd    (fft_nd),
    .fft_ovf   (fft_ovf),
    .max730    (max730),
    .max850    (max850),
    .bin730    (bin730),
    .bin850    (bin850),
    .valid     (valid),
    .frame_err (frame_err)
  );

  typedef struct packed {
    logic [N-1:0][W-1:0] re;
    logic [N-1:0][W-1:0] im;
    int                  ovf_bin;
    int                  gap_mode;
    logic [W-1:0]        m730;
    logic [BW-1:0]       b730;
    logic [W-1:0]        m850;
    logic [BW-1:0]       b850;
    bit                  err;
  } vec_t;

  typedef struct packed {
    logic [W-1:0]  m730;
    logic [BW-1:0] b730;
    logic [W-1:0]  m850;
    logic [BW-1:0] b850;
    bit            err;
    int            acc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t expq[$];
  exp_t prev;
  exp_t mon_e;
  vec_t vecs [NV];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_mag(input int re, input int im);
    int m;
`ifdef PEAK_MAG_SQUARED_EN
    m = (re * re + im * im) / 2048;
`else
    m = iabs(re) + iabs(im);
`endif
    return (m > 4095) ? 4095 : m;
  endfunction

  function automatic exp_t ref_frame(input vec_t v, input exp_t last);
    exp_t e;
    int   best, m;
    e = '0;
    best = 0;
    e.b730 = BW'(LO730);
    for (int b = LO730; b <= HI730; b++) begin
      m = ref_mag(sx(v.re[b]), sx(v.im[b]));
      if (m > best) begin best = m; e.b730 = BW'(b); end
    end
    e.m730 = W'(best);
    best = 0;
    e.b850 = BW'(LO850);
    for (int b = LO850; b <= HI850; b++) begin
      m = ref_mag(sx(v.re[b]), sx(v.im[b]));
      if (m > best) begin best = m; e.b850 = BW'(b); end
    end
    e.m850 = W'(best);
    e.err = (v.ovf_bin >= 0);
    if (e.err) begin
      e.m730 = last.m730; e.b730 = last.b730;
      e.m850 = last.m850; e.b850 = last.b850;
    end
    return e;
  endfunction

  function automatic exp_t row_exp(input vec_t v);
    exp_t e;
    e = '0;
    e.m730 = v.m730; e.b730 = v.b730;
    e.m850 = v.m850; e.b850 = v.b850;
    e.err  = v.err;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd12();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 12'h800;
    if (sel == 1) return 12'h7FF;
    return W'($urandom_range(0, 4095));
  endfunction

  // ---------------- table helpers ----------------
  task automatic set_bin(input int i, input int b, input int re, input int im);
    vecs[i].re[b] = re[W-1:0];
    vecs[i].im[b] = im[W-1:0];
  endtask

  task automatic set_row(input int i, input int ovf, input int gap, input int m730,
                         input int b730, input int m850, input int b850, input bit err);
    vecs[i].ovf_bin  = ovf;
    vecs[i].gap_mode = gap;
    vecs[i].m730     = m730[W-1:0];
    vecs[i].b730     = b730[BW-1:0];
    vecs[i].m850     = m850[W-1:0];
    vecs[i].b850     = b850[BW-1:0];
    vecs[i].err      = err;
  endtask

  // gap_mode: 0 continuous, 1 alternating 1/0, 2 random idle cycles before each beat
  task automatic send_frame(input vec_t v, input exp_t e_in);
    exp_t e;
    int   g;
    e = e_in;
    for (int b = 0; b < N; b++) begin
      if (v.gap_mode == 2) begin
        g = $urandom_range(0, 2);
        repeat (g) begin fft_nd = 1'b0; fft_ovf = 1'b0; tick(); end
      end
      fft_x   = {v.im[b], v.re[b]};
      fft_nd  = 1'b1;
      fft_ovf = (b == v.ovf_bin);
      tick();
      if (b == N - 1) begin
        e.acc = cyc;
        expq.push_back(e);
      end
      if (v.gap_mode == 1) begin fft_nd = 1'b0; fft_ovf = 1'b0; tick(); end
    end
    fft_nd  = 1'b0;
    fft_ovf = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && expq.size() != 0; i++) tick();
    if (expq.size() != 0) begin
      chk("missing_valid", expq.size(), 0);
      expq.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_max730"}, max730, 0);
    chk({tag, "_bin730"}, bin730, 0);
    chk({tag, "_max850"}, max850, 0);
    chk({tag, "_bin850"}, bin850, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask

  // ---------------- publish monitor ----------------
  always @(negedge clk) begin
    if (reset_n && valid) begin
      if (expq.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        mon_e = expq.pop_front();
        $display("publish cyc=%0d max730=%0d bin730=%0d max850=%0d bin850=%0d frame_err=%0d",
                 cyc, max730, bin730, max850, bin850, frame_err);
        chk("latency", cyc - mon_e.acc, LAT);
        chk("max730", max730, mon_e.m730);
        chk("bin730", bin730, mon_e.b730);
        chk("max850", max850, mon_e.m850);
        chk("bin850", bin850, mon_e.b850);
        chk("frame_err", frame_err, mon_e.err);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    exp_t e;

    reset_n = 1'b0;
    fft_nd  = 1'b0;
    fft_ovf = 1'b0;
    fft_x   = '0;
    prev    = '0;
    for (int i = 0; i < NV; i++) begin
      vecs[i] = '0;
      vecs[i].ovf_bin = -1;
    end

`ifdef PEAK_MAG_SQUARED_EN
    set_bin(0, 2, 1024, 1024);
    set_row(0, -1, 0, 1024, 2, 0, 5, 1'b0);
`else
    set_bin(0, 2, 100, -50);   set_bin(0, 6, -300, 0);
    set_row(0, -1, 0, 150, 2, 300, 6, 1'b0);
    set_bin(1, 0, -2048, -2048); set_bin(1, 1, -2048, -2048);
    set_bin(1, 3, -2048, -2048); set_bin(1, 10, 2047, 2047);
    set_row(1, -1, 0, 4095, 1, 0, 5, 1'b0);
    set_bin(2, 3, 10, -20);    set_bin(2, 7, 0, 500);
    set_row(2, -1, 0, 30, 3, 500, 7, 1'b0);
    set_bin(3, 1, 1000, 1000); set_bin(3, 5, -1, -1);
    set_row(3, 9, 0, 30, 3, 500, 7, 1'b1);
    set_bin(4, 2, -7, 3);      set_bin(4, 5, 4, 4);   set_bin(4, 6, 4, 4);
    set_row(4, -1, 0, 10, 2, 8, 5, 1'b0);
    set_bin(5, 1, -100, 200);  set_bin(5, 2, 50, 50); set_bin(5, 3, 0, -301);
    set_bin(5, 5, 1, 0);       set_bin(5, 7, 2047, -2048);
    set_row(5, -1, 1, 301, 3, 4095, 7, 1'b0);
    vecs[6] = vecs[5];
    vecs[6].gap_mode = 0;
`endif

    repeat (3) tick();
    chk_zero("rst");
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      e = row_exp(vecs[i]);
      send_frame(vecs[i], e);
      if (!e.err) prev = e;
    end
    wait_drain();

    // partial frame abandoned by reset
    for (int b = 0; b < 7; b++) begin
      fft_x = {12'h400, 12'h3FF};
      fft_nd = 1'b1;
      tick();
    end
    fft_nd  = 1'b0;
    reset_n = 1'b0;
    tick();
    chk_zero("midrst");
    reset_n = 1'b1;
    prev = '0;
    repeat (6) tick();

    v = vecs[0];
    e = ref_frame(v, prev);
    send_frame(v, e);
    if (!e.err) prev = e;

    for (int f = 0; f < 24; f++) begin
      v = '0;
      for (int b = 0; b < N; b++) begin
        v.re[b] = rnd12();
        v.im[b] = rnd12();
      end
      v.ovf_bin  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, N - 1)) : -1;
      v.gap_mode = $urandom_range(0, 2);
      e = ref_frame(v, prev);
      send_frame(v, e);
      if (!e.err) prev = e;
    end
    wait_drain();
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
